// File: rtl/neighbor_vector_builder.sv
// Builds the 8-bit neighbour-alive vector of one grid cell by reading its eight neighbours in sequence.
// Edge behaviour: define TORUS_WRAP_EN to wrap coordinates; otherwise off-grid neighbours read as dead.
module neighbor_vector_builder #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(GRID_W)-1:0] cell_x,
  input  logic [$clog2(GRID_H)-1:0] cell_y,
  output logic                      busy,
  output logic [$clog2(GRID_W)-1:0] mem_x,
  output logic [$clog2(GRID_H)-1:0] mem_y,
  output logic                      mem_rd_en,
  input  logic                      mem_rd_data,
  output logic [7:0]                vec_out,
  output logic                      vec_valid,
  input  logic                      vec_ready
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_t;

  state_t          state, state_nxt;
  logic [3:0]      idx, idx_nxt;
  logic            accept, issue;

  logic [XW-1:0]   lat_x;
  logic [YW-1:0]   lat_y;
  logic            rd_slot, cap_vld, cap_en;
  logic [2:0]      rd_idx, cap_idx;

  logic [1:0]      dxc, dyc;
  logic [XW:0]     xs;
  logic [YW:0]     ys;
  logic            x_in, y_in, in_grid;
  logic [XW-1:0]   xa;
  logic [YW-1:0]   ya;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // FETCH spends idx 0..7 issuing reads and idx 8 waiting for the last one to reach the port.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          idx_nxt   = '0;
          accept    = 1'b1;
        end
      end
      FETCH: begin
        if (idx == 4'd8) begin
          state_nxt = DRAIN;
        end else begin
          idx_nxt = idx + 4'd1;
          issue   = 1'b1;
        end
      end
      DRAIN:   state_nxt = PRESENT;
      PRESENT: if (vec_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign vec_valid = (state == PRESENT);

  // Offset codes: 0 means -1, 1 means 0, 2 means +1.
  always_comb begin
    dxc = 2'd2;
    dyc = 2'd2;
    case (idx[2:0])
      3'd0: begin dxc = 2'd0; dyc = 2'd0; end
      3'd1: begin dxc = 2'd1; dyc = 2'd0; end
      3'd2: begin dxc = 2'd2; dyc = 2'd0; end
      3'd3: begin dxc = 2'd0; dyc = 2'd1; end
      3'd4: begin dxc = 2'd2; dyc = 2'd1; end
      3'd5: begin dxc = 2'd0; dyc = 2'd2; end
      3'd6: begin dxc = 2'd1; dyc = 2'd2; end
      default: begin dxc = 2'd2; dyc = 2'd2; end
    endcase
  end

  // One extra bit keeps both -1 at zero (all ones) and +1 at the far edge out of range.
  always_comb begin
    xs   = {1'b0, lat_x} + (XW+1)'(dxc) - (XW+1)'(1);
    ys   = {1'b0, lat_y} + (YW+1)'(dyc) - (YW+1)'(1);
    x_in = (xs < (XW+1)'(GRID_W));
    y_in = (ys < (YW+1)'(GRID_H));
`ifdef TORUS_WRAP_EN
    xa      = x_in ? xs[XW-1:0] : ((dxc == 2'd0) ? XW'(GRID_W - 1) : '0);
    ya      = y_in ? ys[YW-1:0] : ((dyc == 2'd0) ? YW'(GRID_H - 1) : '0);
    in_grid = 1'b1;
`else
    xa      = xs[XW-1:0];
    ya      = ys[YW-1:0];
    in_grid = x_in & y_in;
`endif
  end

  // Read port is registered; the memory answers one cycle after the strobe, so a
  // capture stage tracks which vector bit the returning data belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_x     <= '0;
      lat_y     <= '0;
      mem_x     <= '0;
      mem_y     <= '0;
      mem_rd_en <= 1'b0;
      rd_slot   <= 1'b0;
      rd_idx    <= '0;
      cap_vld   <= 1'b0;
      cap_en    <= 1'b0;
      cap_idx   <= '0;
      vec_out   <= '0;
    end else begin
      if (accept) begin
        lat_x   <= cell_x;
        lat_y   <= cell_y;
        vec_out <= '0;
      end
      rd_slot   <= issue;
      rd_idx    <= idx[2:0];
      mem_rd_en <= issue & in_grid;
      if (issue && in_grid) begin
        mem_x <= xa;
        mem_y <= ya;
      end
      cap_vld <= rd_slot;
      cap_idx <= rd_idx;
      cap_en  <= mem_rd_en;
      if (cap_vld) vec_out[cap_idx] <= cap_en & mem_rd_data;
    end
  end

endmodule

// File: tb/tb_neighbor_vector_builder.sv
// Directed and randomized checks of neighbor_vector_builder against a grid-level reference model.
module tb_neighbor_vector_builder;

  localparam int W = 16;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst, start, vec_ready, mem_rd_data;
  logic       busy, mem_rd_en, vec_valid;
  logic [3:0] cell_x, cell_y, mem_x, mem_y;
  logic [7:0] vec_out;

  int vectors = 0;
  int miscompares = 0;

  logic       grid [H][W];
  logic [7:0] exp_vec, got_vec;
  logic [7:0] expq[$];
  logic [7:0] rdq[$];
  logic [3:0] last_x, last_y;

  always #5 clk = ~clk;

  neighbor_vector_builder #(.GRID_W(W), .GRID_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .cell_x(cell_x), .cell_y(cell_y),
    .busy(busy), .mem_x(mem_x), .mem_y(mem_y), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .vec_out(vec_out), .vec_valid(vec_valid),
    .vec_ready(vec_ready)
  );

  // Synchronous grid memory: data follows the strobe by one cycle.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= grid[mem_y][mem_x];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every read address; the address must not move while the strobe is low.
  always @(negedge clk) begin
    if (rst) begin
      last_x = '0;
      last_y = '0;
    end else if (mem_rd_en) begin
      rdq.push_back({mem_x, mem_y});
      last_x = mem_x;
      last_y = mem_y;
    end else begin
      chk("addr_hold", {mem_x, mem_y}, {last_x, last_y});
    end
  end

  function automatic void fill(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        grid[y][x] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
  endfunction

  function automatic void model(input int x, input int y);
    int dx, dy, nx, ny;
    exp_vec = '0;
    expq.delete();
    for (int k = 0; k < 8; k++) begin
      dx = (k == 0 || k == 3 || k == 5) ? -1 : ((k == 1 || k == 6) ? 0 : 1);
      dy = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
      nx = x + dx;
      ny = y + dy;
`ifdef TORUS_WRAP_EN
      nx = (nx + W) % W;
      ny = (ny + H) % H;
`endif
      if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
        exp_vec[k] = grid[ny][nx];
        expq.push_back({4'(nx), 4'(ny)});
      end
    end
  endfunction

  task automatic run_op(input int x, input int y, input int hold);
    int waited;
    model(x, y);
    @(negedge clk);
    start = 1'b1; cell_x = 4'(x); cell_y = 4'(y);
    rdq.delete();
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        chk("busy_on_accept", busy, 1);
      end
      if (i == 9) chk("valid_early", vec_valid, 0);
    end
    chk("latency", vec_valid, 1);
    waited = 0;
    while (!vec_valid && waited < 20) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    got_vec = vec_out;
    chk("vec_out", vec_out, exp_vec);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; cell_x = 4'($urandom_range(0, 15)); cell_y = 4'($urandom_range(0, 15));
      @(posedge clk); @(negedge clk);
      chk("hold_vec", vec_out, exp_vec);
      chk("hold_busy", busy, 1);
      chk("hold_valid", vec_valid, 1);
    end
    vec_ready = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; vec_ready = 1'b0;
    chk("hs_valid", vec_valid, 0);
    chk("hs_idle", busy, 0);
    chk("rd_count", rdq.size(), expq.size());
    for (int j = 0; j < expq.size() && j < rdq.size(); j++) chk("rd_addr", rdq[j], expq[j]);
    @(posedge clk); @(negedge clk);
    chk("idle_stay", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; vec_ready = 1'b0; cell_x = '0; cell_y = '0;
    fill(0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_valid", vec_valid, 0);
    chk("rst_vec", vec_out, 0);
    chk("rst_mem_xy", {mem_x, mem_y}, 0);
    rst = 1'b0;

    // Interior cell, centre dead, everything else alive.
    fill(1); grid[5][5] = 1'b0;
    run_op(5, 5, 0);
    chk("interior_ff", got_vec, 8'hFF);

    fill(1);
    run_op(0, 0, 0);
`ifdef TORUS_WRAP_EN
    chk("corner_all_wrap", got_vec, 8'hFF);
`else
    chk("corner_all_nowrap", got_vec, 8'hD0);
`endif

    fill(0); grid[15][15] = 1'b1;
    run_op(0, 0, 0);
`ifdef TORUS_WRAP_EN
    chk("corner_wrap", got_vec, 8'h01);
    chk("corner_wrap_k0_addr", rdq.size() > 0 ? rdq[0] : 8'h00, 8'hFF);
`else
    chk("corner_single_nowrap", got_vec, 8'h00);
`endif

    fill(1);
    run_op(15, 15, 0);
    fill(2);
    run_op(7, 3, 5);

    // Reset during FETCH slot 4 aborts the build.
    fill(1);
    @(negedge clk);
    start = 1'b1; cell_x = 4'd6; cell_y = 4'd6;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_valid", vec_valid, 0);
    chk("abort_vec", vec_out, 0);
    chk("abort_mem_xy", {mem_x, mem_y}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    fill(0);
    run_op(1, 1, 0);
    chk("after_reset_dead", got_vec, 8'h00);

    repeat (24) begin
      int x, y, r;
      fill(2);
      r = $urandom_range(0, 3);
      x = (r == 0) ? 0 : ((r == 1) ? 15 : $urandom_range(0, 15));
      r = $urandom_range(0, 3);
      y = (r == 0) ? 0 : ((r == 1) ? 15 : $urandom_range(0, 15));
      run_op(x, y, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
